// File: rtl/strb_bus_rr_arbiter.sv
// ---------------------------------------------------------------------------
// strb_bus_rr_arbiter
//
// Shares one strobe/ack slave between NUM_MST masters using round-robin
// arbitration. Each master sees the same protocol it would see on a direct
// slave connection. A wait timer aborts a transaction whose slave never acks.
//
// Handshake (both sides): a requester raises strb with we/addr/wdata stable
// and holds them until it samples the one-cycle completion (ack, or err on
// the master side); the strb drop then follows in the next cycle.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   m_strb/m_we         per-master strobe / write enable
//   m_addr/m_wdata      packed per-master address / write data
//   m_rdata             shared read data, valid with the owner's m_ack
//   m_ack/m_err         one-cycle completion / timeout-abort pulses
//   gnt                 one-hot grant (nonzero in BUSY and DONE)
//   busy                high whenever the arbiter is not idle
//   s_we/s_strb/s_addr/s_wdata/s_rdata/s_ack   slave-side bus
// ---------------------------------------------------------------------------
module strb_bus_rr_arbiter #(
    parameter int NUM_MST = 4,
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_MST-1:0]    m_strb,
    input  logic [NUM_MST-1:0]    m_we,
    input  logic [NUM_MST*AW-1:0] m_addr,
    input  logic [NUM_MST*DW-1:0] m_wdata,
    output logic [DW-1:0]         m_rdata,
    output logic [NUM_MST-1:0]    m_ack,
    output logic [NUM_MST-1:0]    m_err,
    output logic [NUM_MST-1:0]    gnt,
    output logic                  busy,
    output logic                  s_we,
    output logic                  s_strb,
    output logic [AW-1:0]         s_addr,
    output logic [DW-1:0]         s_wdata,
    input  logic [DW-1:0]         s_rdata,
    input  logic                  s_ack
);

    localparam int PW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [PW-1:0]  win_q, win_d;
    logic [TW-1:0]  timer_q, timer_d;

    logic                  s_strb_d, s_we_d, busy_d;
    logic [AW-1:0]         s_addr_d;
    logic [DW-1:0]         s_wdata_d, m_rdata_d;
    logic [NUM_MST-1:0]    m_ack_d, m_err_d, gnt_d;

    // Round-robin pick: first requesting master scanning ptr, ptr+1, ...
    logic          req_found;
    logic [PW-1:0] req_idx;

    always_comb begin
        int cand;
        req_found = 1'b0;
        req_idx   = '0;
        cand      = 0;
        for (int k = 0; k < NUM_MST; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NUM_MST) begin
                cand = cand - NUM_MST;
            end
            if (!req_found && m_strb[cand]) begin
                req_found = 1'b1;
                req_idx   = PW'(cand);
            end
        end
    end

    // Pointer moves just past the master that finished (ack or abort).
    logic [PW-1:0] ptr_after_win;
    assign ptr_after_win = (win_q == PW'(NUM_MST - 1)) ? '0 : win_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        timer_d   = timer_q;
        s_strb_d  = s_strb;
        s_we_d    = s_we;
        s_addr_d  = s_addr;
        s_wdata_d = s_wdata;
        m_rdata_d = m_rdata;
        m_ack_d   = m_ack;
        m_err_d   = m_err;
        gnt_d     = gnt;

        case (state_q)
            S_IDLE: begin
                if (req_found) begin
                    win_d          = req_idx;
                    s_we_d         = m_we[req_idx];
                    s_addr_d       = m_addr[int'(req_idx)*AW +: AW];
                    s_wdata_d      = m_wdata[int'(req_idx)*DW +: DW];
                    s_strb_d       = 1'b1;
                    gnt_d          = '0;
                    gnt_d[req_idx] = 1'b1;
                    timer_d        = '0;
                    state_d        = S_BUSY;
                end
            end
            S_BUSY: begin
                // An ack arriving in the last allowed cycle still wins.
                if (s_ack) begin
                    s_strb_d       = 1'b0;
                    m_ack_d[win_q] = 1'b1;
                    m_rdata_d      = s_rdata;
                    ptr_d          = ptr_after_win;
                    state_d        = S_DONE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    s_strb_d       = 1'b0;
                    m_err_d[win_q] = 1'b1;
                    ptr_d          = ptr_after_win;
                    state_d        = S_DONE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_DONE: begin
                // One dead cycle lets the finished master drop its strobe
                // before arbitration looks at m_strb again.
                m_ack_d = '0;
                m_err_d = '0;
                gnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            timer_q <= '0;
            s_strb  <= 1'b0;
            s_we    <= 1'b0;
            s_addr  <= '0;
            s_wdata <= '0;
            m_rdata <= '0;
            m_ack   <= '0;
            m_err   <= '0;
            gnt     <= '0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            timer_q <= timer_d;
            s_strb  <= s_strb_d;
            s_we    <= s_we_d;
            s_addr  <= s_addr_d;
            s_wdata <= s_wdata_d;
            m_rdata <= m_rdata_d;
            m_ack   <= m_ack_d;
            m_err   <= m_err_d;
            gnt     <= gnt_d;
            busy    <= busy_d;
        end
    end

endmodule

// File: tb/tb_strb_bus_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_strb_bus_rr_arbiter
//
// Directed bench for strb_bus_rr_arbiter (NUM_MST=4, AW=8, DW=8, TIMEOUT=15).
// A transaction-level reference model (owner / cycles waited / cool-down)
// predicts every output each cycle; directed tests add literal checks.
// The slave returns s_rdata = s_addr ^ 8'h4A and acks in the ack_at-th
// cycle its strobe is seen high (ack_at = 0 means it never acks).
// ---------------------------------------------------------------------------
module tb_strb_bus_rr_arbiter;

    localparam int N       = 4;
    localparam int AW      = 8;
    localparam int DW      = 8;
    localparam int TIMEOUT = 15;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]    m_strb, m_we;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [DW-1:0]   m_rdata;
    logic [N-1:0]    m_ack, m_err, gnt;
    logic            busy, s_we, s_strb, s_ack;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata, s_rdata;

    strb_bus_rr_arbiter #(.NUM_MST(N), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .m_strb(m_strb), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .m_err(m_err), .gnt(gnt), .busy(busy),
        .s_we(s_we), .s_strb(s_strb), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ack(s_ack)
    );

    // ---------------- scoreboard counters ----------------
    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    int  md_owner;   // -1 when no transaction is in flight
    int  md_wait;    // slave cycles spent waiting in the current transaction
    bit  md_cool;    // one-cycle gap after a completion
    int  md_ptr;
    int  md_c;
    logic            e_s_strb, e_s_we, e_busy;
    logic [AW-1:0]   e_s_addr;
    logic [DW-1:0]   e_s_wdata, e_m_rdata;
    logic [N-1:0]    e_ack, e_err, e_gnt;

    always @(posedge clk) begin
        if (rst) begin
            md_owner = -1; md_wait = 0; md_cool = 0; md_ptr = 0;
            e_s_strb = 0; e_s_we = 0; e_s_addr = '0; e_s_wdata = '0;
            e_m_rdata = '0; e_ack = '0; e_err = '0; e_gnt = '0;
        end else if (md_cool) begin
            e_ack = '0; e_err = '0; e_gnt = '0;
            md_cool = 0;
        end else if (md_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                md_c = (md_ptr + k) % N;
                if (md_owner < 0 && m_strb[md_c]) md_owner = md_c;
            end
            if (md_owner >= 0) begin
                e_s_strb  = 1;
                e_s_we    = m_we[md_owner];
                e_s_addr  = m_addr[md_owner*AW +: AW];
                e_s_wdata = m_wdata[md_owner*DW +: DW];
                e_gnt     = '0;
                e_gnt[md_owner] = 1'b1;
                md_wait   = 0;
            end
        end else begin
            md_wait++;
            if (s_ack) begin
                e_s_strb = 0;
                e_ack[md_owner] = 1'b1;
                e_m_rdata = s_rdata;
                md_ptr = (md_owner + 1) % N;
                md_owner = -1;
                md_cool = 1;
            end else if (md_wait == TIMEOUT) begin
                e_s_strb = 0;
                e_err[md_owner] = 1'b1;
                md_ptr = (md_owner + 1) % N;
                md_owner = -1;
                md_cool = 1;
            end
        end
        e_busy = (md_owner >= 0) || md_cool;
    end

    // Every-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_s_strb",  s_strb,  e_s_strb);
            chk("cyc_s_we",    s_we,    e_s_we);
            chk("cyc_s_addr",  s_addr,  e_s_addr);
            chk("cyc_s_wdata", s_wdata, e_s_wdata);
            chk("cyc_m_rdata", m_rdata, e_m_rdata);
            chk("cyc_m_ack",   m_ack,   e_ack);
            chk("cyc_m_err",   m_err,   e_err);
            chk("cyc_gnt",     gnt,     e_gnt);
            chk("cyc_busy",    busy,    e_busy);
        end
    end

    // ---------------- driver state ----------------
    int   ack_at;
    int   scnt;
    int   cyc;
    bit   cont [N];
    int   ack_cnt [N];
    int   err_cnt [N];
    logic [N-1:0] prev_gnt;
    int   gnt_log[$];
    int   ack_t[$];
    logic [31:0] exp_q[$];

    task automatic clr();
        for (int i = 0; i < N; i++) begin
            ack_cnt[i] = 0;
            err_cnt[i] = 0;
        end
        gnt_log.delete();
        ack_t.delete();
    endtask

    // One cycle: monitor, master agent, slave responder.
    task automatic tick();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (m_ack[i]) ack_cnt[i]++;
            if (m_err[i]) err_cnt[i]++;
        end
        if (gnt != '0 && prev_gnt == '0) begin
            for (int i = 0; i < N; i++) if (gnt[i]) gnt_log.push_back(i);
        end
        if (m_ack != '0) ack_t.push_back(cyc);
        prev_gnt = gnt;
        for (int i = 0; i < N; i++) begin
            if (m_ack[i] || m_err[i]) begin
                if (cont[i]) begin
                    m_addr[i*AW +: AW]  = m_addr[i*AW +: AW] + 8'h01;
                    m_wdata[i*DW +: DW] = m_wdata[i*DW +: DW] + 8'h11;
                end else begin
                    m_strb[i] = 1'b0;
                end
            end
        end
        if (s_strb === 1'b1) begin
            scnt++;
            s_ack = (ack_at != 0 && scnt == ack_at);
        end else begin
            scnt  = 0;
            s_ack = 1'b0;
        end
        s_rdata = s_addr ^ 8'h4A;
    endtask

    task automatic request(input int i, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        m_we[i] = we;
        m_addr[i*AW +: AW]  = a;
        m_wdata[i*DW +: DW] = d;
        m_strb[i] = 1'b1;
    endtask

    task automatic drain(input string name);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 120; t++) begin
            tick();
            if (m_strb == '0 && busy == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, ok, 1'b1);
    endtask

    // Waits until any completion pulse; returns 1 if it arrived in time.
    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 60; t++) begin
            tick();
            if (m_ack != '0 || m_err != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 30; t++) begin
            tick();
            if (gnt != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_strb(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 30; t++) begin
            tick();
            if (s_strb) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        bit ok;
        int cnt;
        rst = 1'b1;
        m_strb = '0; m_we = '0; m_addr = '0; m_wdata = '0;
        s_ack = 1'b0; s_rdata = '0;
        ack_at = 1; scnt = 0; cyc = 0; prev_gnt = '0;
        for (int i = 0; i < N; i++) cont[i] = 1'b0;
        clr();
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_s_strb",  s_strb,  1'b0);
        chk("rst_gnt",     gnt,     4'b0000);
        chk("rst_busy",    busy,    1'b0);
        chk("rst_m_rdata", m_rdata, 8'h00);
        rst = 1'b0;

        // Fairness: all four request continuously from reset, zero-wait slave.
        clr();
        ack_at = 1;
        for (int i = 0; i < N; i++) begin
            cont[i] = 1'b1;
            request(i, i[0], 8'h40 + 8'(i), 8'h10 * 8'(i));
        end
        for (int t = 0; t < 60 && ack_t.size() < 8; t++) tick();
        chk("t3_ack_total", ack_t.size(), 8);
        exp_q = '{0, 1, 2, 3, 0, 1, 2, 3};
        for (int i = 0; i < 8; i++)
            chk("t3_order", (i < gnt_log.size()) ? gnt_log[i] : 32'hFFFF_FFFF, exp_q[i]);
        for (int i = 1; i < 8; i++)
            chk("t3_spacing", (i < ack_t.size()) ? ack_t[i] - ack_t[i-1] : 0, 3);
        for (int i = 0; i < N; i++) cont[i] = 1'b0;
        drain("t3_drain");

        // Write by master 1, slave acks in the 3rd BUSY cycle.
        clr();
        ack_at = 3;
        request(1, 1'b1, 8'h3C, 8'hA5);
        cnt = 0;
        ok = 1'b0;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (s_strb) begin
                cnt++;
                chk("t1_s_we",    s_we,    1'b1);
                chk("t1_s_addr",  s_addr,  8'h3C);
                chk("t1_s_wdata", s_wdata, 8'hA5);
                chk("t1_gnt",     gnt,     4'b0010);
            end
            if (m_ack[1]) begin
                chk("t1_done_strb", s_strb, 1'b0);
                chk("t1_done_gnt",  gnt,    4'b0010);
                ok = 1'b1;
                break;
            end
        end
        chk("t1_completed", ok, 1'b1);
        chk("t1_busy_len", cnt, 3);
        drain("t1_drain");
        chk("t1_ack_count", ack_cnt[1], 1);
        chk("t1_err_count", err_cnt[1], 0);

        // Read by master 2 from 0x10 -> slave data 0x5A.
        clr();
        ack_at = 1;
        request(2, 1'b0, 8'h10, 8'h00);
        wait_done(ok);
        chk("t2_completed", ok, 1'b1);
        chk("t2_m_ack",   m_ack,   4'b0100);
        chk("t2_m_rdata", m_rdata, 8'h5A);
        drain("t2_drain");
        chk("t2_rdata_held", m_rdata, 8'h5A);

        // Timeout on master 0 with master 3 pending.
        clr();
        ack_at = 0;
        request(0, 1'b0, 8'h20, 8'h00);
        wait_strb(ok);
        chk("t4_started", ok, 1'b1);
        request(3, 1'b1, 8'h44, 8'h99);
        cnt = 1;
        ok = 1'b0;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (m_ack != '0 || m_err != '0) begin
                ok = 1'b1;
                break;
            end
            if (s_strb) cnt++;
        end
        chk("t4_aborted", ok, 1'b1);
        chk("t4_strb_cycles", cnt, 15);
        chk("t4_m_err", m_err, 4'b0001);
        chk("t4_m_ack", m_ack, 4'b0000);
        chk("t4_s_strb", s_strb, 1'b0);
        ack_at = 2;
        wait_gnt(ok);
        chk("t4_next_gnt", gnt, 4'b1000);
        drain("t4_drain");
        chk("t4_err_count", err_cnt[0], 1);
        chk("t4_ack0_count", ack_cnt[0], 0);
        chk("t4_ack3_count", ack_cnt[3], 1);

        // Ack in the 15th BUSY cycle collides with the timeout.
        clr();
        ack_at = 15;
        request(1, 1'b0, 8'h31, 8'h00);
        wait_done(ok);
        chk("t5_completed", ok, 1'b1);
        chk("t5_m_ack",   m_ack,   4'b0010);
        chk("t5_m_err",   m_err,   4'b0000);
        chk("t5_m_rdata", m_rdata, 8'h7B);
        drain("t5_drain");
        chk("t5_err_count", err_cnt[1], 0);

        // Reset in the middle of master 2's BUSY.
        clr();
        ack_at = 0;
        request(2, 1'b0, 8'h55, 8'h00);
        wait_strb(ok);
        chk("t6_started", ok, 1'b1);
        tick(); tick(); tick();
        rst = 1'b1;
        m_strb[2] = 1'b0;
        tick();
        rst = 1'b0;
        chk("t6_s_strb", s_strb, 1'b0);
        chk("t6_gnt",    gnt,    4'b0000);
        chk("t6_busy",   busy,   1'b0);
        tick(); tick(); tick(); tick();
        chk("t6_no_ack", ack_cnt[2], 0);
        chk("t6_no_err", err_cnt[2], 0);
        ack_at = 1;
        request(1, 1'b1, 8'h61, 8'h16);
        request(3, 1'b1, 8'h63, 8'h36);
        wait_gnt(ok);
        chk("t6_granted", ok, 1'b1);
        chk("t6_first_gnt", gnt, 4'b0010);
        drain("t6_drain");
        chk("t6_ack1", ack_cnt[1], 1);
        chk("t6_ack3", ack_cnt[3], 1);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/strb_bus_rr_arbiter.md
Name: strb_bus_rr_arbiter

Overview:
- Shares one strobe/ack memory-bus slave (we, strb, addr, wdata, rdata, ack) between NUM_MST requesting masters.
- Arbitration is round-robin.
- Each master sees the same strobe/ack protocol it would see on a direct slave connection.
- A wait timeout stops a hung slave from locking the bus.
- Sits between the bus masters (test drivers or CPU-side agents) and the register/memory slave.

Parameters:
- NUM_MST, 4, number of requesting masters (2..8).
- AW, 8, address width.
- DW, 8, data width.
- TIMEOUT, 15, maximum BUSY cycles without s_ack before the transaction is aborted (>=2).

Ports:
- clk  in  1  rising-edge clock for all logic.
- rst  in  1  synchronous, active-high reset.
- m_strb  in  NUM_MST  per-master request strobe.
- m_we  in  NUM_MST  per-master write enable (1 = write, 0 = read).
- m_addr  in  NUM_MST*AW  packed addresses; master i at [i*AW +: AW].
- m_wdata  in  NUM_MST*DW  packed write data; master i at [i*DW +: DW].
- m_rdata  out  DW  read data, shared by all masters; valid when that master's m_ack pulses.
- m_ack  out  NUM_MST  one-cycle completion pulse to the granted master.
- m_err  out  NUM_MST  one-cycle timeout-abort pulse to the granted master.
- gnt  out  NUM_MST  one-hot grant; nonzero in BUSY and DONE only.
- busy  out  1  high whenever state != IDLE.
- s_we  out  1  slave write enable.
- s_strb  out  1  slave strobe.
- s_addr  out  AW  slave address.
- s_wdata  out  DW  slave write data.
- s_rdata  in  DW  slave read data.
- s_ack  in  1  slave acknowledge.

Behaviour:
- Master protocol:
  - A master raises m_strb[i] with m_we/m_addr/m_wdata stable.
  - It holds them until it samples m_ack[i] or m_err[i] high.
  - It drops m_strb[i] in the following cycle.
- All outputs are registered.
- Reset (rst=1 at an edge) takes effect at that edge and sets:
  - state = IDLE, ptr = 0;
  - s_strb, s_we, s_addr, s_wdata, m_rdata, m_ack, m_err, gnt, timer all = 0.
- Reset mid-transaction: s_strb drops at the reset edge, no m_ack or m_err is issued, and the transaction is lost.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If any m_strb bit is set, select the first set bit scanning ptr, ptr+1, ... (mod NUM_MST).
  - Register the winner's we/addr/wdata onto s_we/s_addr/s_wdata.
  - Set s_strb=1, set gnt one-hot, clear timer, go to BUSY.
  - If no requests, stay in IDLE.
- BUSY:
  - s_strb and the s_* fields hold the captured values; later master input changes are ignored.
  - On s_ack=1: s_strb<=0, m_ack[w]<=1, m_rdata<=s_rdata (captured for writes too), ptr<=(w+1) mod NUM_MST, go to DONE.
  - Else if timer==TIMEOUT-1: s_strb<=0, m_err[w]<=1, ptr<=(w+1) mod NUM_MST, go to DONE.
  - Else timer<=timer+1.
  - s_ack and timeout in the same cycle: the ack wins and no m_err is issued.
- DONE (exactly one cycle):
  - Clear m_ack, m_err and gnt; go to IDLE.
  - This cycle absorbs the master's strb drop, so a finished request is never re-granted.
- s_ack while in IDLE or DONE is ignored.
- Timer width is clog2(TIMEOUT+1) and it never wraps.
- Zero-wait slave (ack in the first BUSY cycle): one transaction every 3 cycles.
- A master that drops m_strb while granted still gets its m_ack or m_err; the captured transaction completes.
- m_rdata holds its last captured value until the next completion.
- Round-robin fairness: a master that keeps requesting waits at most NUM_MST-1 transactions before it is granted.

Test Plan:
1. Write:
   - Stimulus: m_strb[1]=1, we=1, addr=0x3C, wdata=0xA5; slave acks in the 3rd BUSY cycle.
   - Required: s_we=1, s_addr=0x3C, s_wdata=0xA5 and gnt=0010 throughout BUSY; exactly one m_ack[1] pulse; s_strb low in DONE.
2. Read:
   - Stimulus: master 2 reads addr 0x10; slave returns s_rdata=0x5A with s_ack.
   - Required: m_rdata=0x5A in the same cycle m_ack[2]=1; m_rdata still 0x5A afterwards.
3. Fairness:
   - Stimulus: all four masters request continuously from reset with a zero-wait slave.
   - Required: grants in order 0,1,2,3,0,...; completions every 3 cycles; no master granted twice in a row.
4. Timeout:
   - Stimulus: master 0 requests; slave never acks; TIMEOUT=15.
   - Required: after 15 BUSY cycles s_strb drops; m_err[0] pulses once, m_ack stays 0; a pending master 3 request is served next.
5. Ack/timeout collision:
   - Stimulus: s_ack asserted in exactly the 15th BUSY cycle.
   - Required: m_ack pulses, m_err stays 0, m_rdata updated.
6. Reset mid-BUSY:
   - Stimulus: assert rst for 1 cycle during BUSY of master 2.
   - Required: s_strb=0 and gnt=0 after the reset edge; no m_ack or m_err; the next simultaneous masters 1 and 3 request grants master 1 first (ptr=0).
